pe_seq_ctrl: RTL and testbench
==============================

PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001: Parameter KMAX, default 8, maximum filter taps (window depth).
REQ-002: Parameter DW, default 16, datapath width, Q7.8 signed.
REQ-003: clk  in  1  single clock; all state updates on posedge clk.
REQ-004: rst  in  1  synchronous, active-high reset.
REQ-005: start  in  1  begin a 1-D convolution job; sampled only in IDLE.
REQ-006: cfg_k  in  $clog2(KMAX)+1  tap count K, legal range 1..KMAX.
REQ-007: cfg_npix  in  8  number of input pixels N in the job.
REQ-008: busy  out  1  high from the cycle after an accepted start until DONE completes.
REQ-009: done  out  1  one-cycle pulse at job end.
REQ-010: wgt_wr_en / wgt_wr_addr / wgt_wr_data  in  1 / $clog2(KMAX) / DW  weight-file write port.
REQ-011: img_valid / img_data  in  1 / DW; img_ready  out  1  pixel stream (valid/ready).
REQ-012: out_valid / out_data  out  1 / DW; out_ready  in  1  result stream (valid/ready).
REQ-013: pe_image_val, pe_weight_val, pe_psum_in  out  DW  operands to the PE.
REQ-014: pe_image_en, pe_weight_en  out  1  PE enables.
REQ-015: pe_psum_out  in  DW  PE result, combinational from PE inputs.

Function
REQ-016: The block SHALL compute y[n] = sum over k=0..K-1 of w[k]*x[n+k] for n = 0..N-K using the PE, producing N-K+1 outputs in order.
REQ-017: The block SHALL hold KMAX weight registers, written by wgt_wr_en only while busy=0; writes while busy=1 SHALL be ignored.
REQ-018: The block SHALL implement states IDLE, FILL, LOADW, MAC, EMIT, FETCH, DONE.
REQ-019: IDLE: start=1 with 1<=cfg_k<=KMAX and cfg_npix>=cfg_k SHALL latch K and N and go to FILL; any other start SHALL be ignored (stay IDLE, busy=0).
REQ-020: FILL: img_ready=1; each handshake SHALL shift the pixel into the window (window[K-1] newest); after K pixels go to LOADW with tap=0 and acc=0.
REQ-021: LOADW: pe_weight_en=1, pe_weight_val=w[tap] for exactly one cycle, then MAC.
REQ-022: MAC: pe_image_en=1, pe_image_val=window[tap], pe_psum_in=acc; acc SHALL capture pe_psum_out; if tap=K-1 go to EMIT, else tap+1 and LOADW.
REQ-023: Outside MAC, pe_image_en SHALL be 0; outside LOADW, pe_weight_en SHALL be 0.
REQ-024: EMIT: out_valid=1, out_data=acc held stable until out_ready=1; on handshake go to FETCH if outputs remain, else DONE.
REQ-025: FETCH: img_ready=1; on handshake shift one pixel into the window, clear acc and tap, go to LOADW.
REQ-026: DONE: done=1 for one cycle, then IDLE.
REQ-027: Per-output latency SHALL be 2K cycles from LOADW entry to out_valid assertion.
REQ-028: Arithmetic (Q7.8 multiply/add, overflow) SHALL be entirely the PE's; the block only passes values.
REQ-029: img_ready SHALL be 0 in all states except FILL and FETCH; pixels beyond N SHALL not be accepted.

Reset
REQ-030: On rst=1 at posedge clk: state=IDLE, busy=0, done=0, out_valid=0, img_ready=0, pe_image_en=0, pe_weight_en=0, acc=0, tap=0, window cleared, all weights 0.
REQ-031: Reset mid-job SHALL abort the job with no further out_valid or done.

Configuration
REQ-032: Macro PE_SEQ_CTRL_RELU_EN defined: out_data SHALL be 0 when acc is negative, else acc.
REQ-033: Macro PE_SEQ_CTRL_RELU_EN undefined: out_data SHALL equal acc unmodified.

Verification
REQ-034: K=3, w={256,256,256}, N=4, x={256,512,768,1024}, out_ready=1 -> outputs 1536 then 2304, done pulse, busy low.
REQ-035: Same job with w={-256,-256,-256} -> outputs 0,0 with RELU_EN; -1536,-2304 without.
REQ-036: out_ready held 0 for 5 cycles during EMIT -> out_valid=1 and out_data constant, img_ready=0, pe enables 0.
REQ-037: start with cfg_k=0, or cfg_npix=2 with cfg_k=3 -> busy stays 0, no img_ready, no done.
REQ-038: rst asserted during second MAC of first output -> next cycle all outputs at reset values; fresh job then produces correct results.
REQ-039: wgt_wr_en pulsed while busy -> weights unchanged, job results match REQ-034.

Source files
------------

// File: rtl/pe_seq_ctrl_if.sv
// Bus bundle for pe_seq_ctrl: job control, weight-file write port, pixel/result
// streams and the operand/result lines to the external processing element.
interface pe_seq_ctrl_if #(
    parameter int unsigned KMAX = 8,
    parameter int unsigned DW   = 16
);
    localparam int unsigned AW = (KMAX > 1) ? $clog2(KMAX) : 1;
    localparam int unsigned KW = $clog2(KMAX) + 1;

    logic          start;
    logic [KW-1:0] cfg_k;
    logic [7:0]    cfg_npix;
    logic          busy;
    logic          done;

    logic          wgt_wr_en;
    logic [AW-1:0] wgt_wr_addr;
    logic [DW-1:0] wgt_wr_data;

    logic          img_valid;
    logic [DW-1:0] img_data;
    logic          img_ready;

    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;

    logic [DW-1:0] pe_image_val;
    logic [DW-1:0] pe_weight_val;
    logic [DW-1:0] pe_psum_in;
    logic          pe_image_en;
    logic          pe_weight_en;
    logic [DW-1:0] pe_psum_out;

    // Controller side
    modport slave (
        input  start, cfg_k, cfg_npix,
        input  wgt_wr_en, wgt_wr_addr, wgt_wr_data,
        input  img_valid, img_data, out_ready, pe_psum_out,
        output busy, done, img_ready, out_valid, out_data,
        output pe_image_val, pe_weight_val, pe_psum_in, pe_image_en, pe_weight_en
    );

    // Job issuer / stream endpoints / PE side
    modport master (
        output start, cfg_k, cfg_npix,
        output wgt_wr_en, wgt_wr_addr, wgt_wr_data,
        output img_valid, img_data, out_ready, pe_psum_out,
        input  busy, done, img_ready, out_valid, out_data,
        input  pe_image_val, pe_weight_val, pe_psum_in, pe_image_en, pe_weight_en
    );
endinterface

// File: rtl/pe_seq_ctrl.sv
// Sequencer driving a single MAC PE to compute a 1-D convolution over a pixel stream.
// Optional macro PE_SEQ_CTRL_RELU_EN clamps negative results to zero on out_data.
module pe_seq_ctrl #(
    parameter int unsigned KMAX = 8,
    parameter int unsigned DW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    pe_seq_ctrl_if.slave    bus
);
    localparam int unsigned AW = (KMAX > 1) ? $clog2(KMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_LOADW, S_MAC, S_EMIT, S_FETCH, S_DONE
    } state_t;

    state_t        state;
    logic [DW-1:0] weights [KMAX];
    logic [DW-1:0] window  [KMAX];
    logic [DW-1:0] acc;
    logic [AW-1:0] tap;
    logic [AW-1:0] k_m1;
    logic [AW-1:0] fill_cnt;
    logic [7:0]    out_cnt;
    logic [7:0]    nout_m1;
    logic          start_ok_c;
    logic          img_hs_c;

    assign start_ok_c = bus.start && (bus.cfg_k != '0) && (32'(bus.cfg_k) <= KMAX)
                        && (32'(bus.cfg_npix) >= 32'(bus.cfg_k));
    assign img_hs_c   = bus.img_valid && bus.img_ready;

    function automatic logic [DW-1:0] out_fmt(input logic [DW-1:0] v);
`ifdef PE_SEQ_CTRL_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.img_ready     <= 1'b0;
            bus.out_valid     <= 1'b0;
            bus.out_data      <= '0;
            bus.pe_image_val  <= '0;
            bus.pe_weight_val <= '0;
            bus.pe_psum_in    <= '0;
            bus.pe_image_en   <= 1'b0;
            bus.pe_weight_en  <= 1'b0;
            acc               <= '0;
            tap               <= '0;
            k_m1              <= '0;
            fill_cnt          <= '0;
            out_cnt           <= '0;
            nout_m1           <= '0;
            for (int i = 0; i < int'(KMAX); i++) begin
                weights[i] <= '0;
                window[i]  <= '0;
            end
        end else begin
            // Weight file is frozen for the duration of a job
            if (!bus.busy && bus.wgt_wr_en) begin
                weights[bus.wgt_wr_addr] <= bus.wgt_wr_data;
            end

            // Window shift on any accepted pixel; window[K-1] holds the newest
            if (img_hs_c) begin
                for (int i = 0; i < int'(KMAX) - 1; i++) begin
                    if (i < int'(k_m1)) begin
                        window[i] <= window[i+1];
                    end
                end
                window[k_m1] <= bus.img_data;
            end

            case (state)
                S_IDLE: begin
                    bus.done <= 1'b0;
                    if (start_ok_c) begin
                        k_m1          <= AW'(bus.cfg_k - 1'b1);
                        nout_m1       <= bus.cfg_npix - 8'(bus.cfg_k);
                        fill_cnt      <= '0;
                        out_cnt       <= '0;
                        bus.busy      <= 1'b1;
                        bus.img_ready <= 1'b1;
                        state         <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (img_hs_c) begin
                        fill_cnt <= fill_cnt + AW'(1);
                        if (fill_cnt == k_m1) begin
                            bus.img_ready     <= 1'b0;
                            acc               <= '0;
                            tap               <= '0;
                            bus.pe_weight_en  <= 1'b1;
                            bus.pe_weight_val <= weights[0];
                            state             <= S_LOADW;
                        end
                    end
                end
                S_LOADW: begin
                    bus.pe_weight_en <= 1'b0;
                    bus.pe_image_en  <= 1'b1;
                    bus.pe_image_val <= window[tap];
                    bus.pe_psum_in   <= acc;
                    state            <= S_MAC;
                end
                S_MAC: begin
                    bus.pe_image_en <= 1'b0;
                    acc             <= bus.pe_psum_out;
                    if (tap == k_m1) begin
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= out_fmt(bus.pe_psum_out);
                        state         <= S_EMIT;
                    end else begin
                        tap               <= tap + AW'(1);
                        bus.pe_weight_en  <= 1'b1;
                        bus.pe_weight_val <= weights[tap + AW'(1)];
                        state             <= S_LOADW;
                    end
                end
                S_EMIT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        out_cnt       <= out_cnt + 8'd1;
                        if (out_cnt == nout_m1) begin
                            bus.done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            bus.img_ready <= 1'b1;
                            state         <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (img_hs_c) begin
                        bus.img_ready     <= 1'b0;
                        acc               <= '0;
                        tap               <= '0;
                        bus.pe_weight_en  <= 1'b1;
                        bus.pe_weight_val <= weights[0];
                        state             <= S_LOADW;
                    end
                end
                S_DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl with a Q7.8 PE model attached to the operand lines.
module tb_pe_seq_ctrl;
    localparam int unsigned KMAX = 8;
    localparam int unsigned DW   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pe_seq_ctrl_if #(.KMAX(KMAX), .DW(DW)) bus ();

    pe_seq_ctrl #(.KMAX(KMAX), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // PE: latches weight on pe_weight_en, result is psum_in + (w * x) >>> 8
    logic signed [DW-1:0]   pe_wreg;
    logic signed [2*DW-1:0] pe_prod;
    always_ff @(posedge clk) begin
        if (rst) pe_wreg <= '0;
        else if (bus.pe_weight_en) pe_wreg <= bus.pe_weight_val;
    end
    always_comb begin
        pe_prod         = $signed(pe_wreg) * $signed(bus.pe_image_val);
        bus.pe_psum_out = bus.pe_psum_in + DW'(pe_prod >>> 8);
    end

    int total = 0;
    int bad   = 0;

    logic signed [DW-1:0] pix [16];
    logic signed [DW-1:0] got [$];
    logic signed [DW-1:0] stall_data;
    int done_cnt, pix_taken, lat_loadw, lat_valid, stall_viol, stall_cycles, proto_viol;
    int stall_req   = 0;
    bit corrupt_req = 1'b0;
    bit timed_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input int k, input logic signed [DW-1:0] w);
        for (int i = 0; i < k; i++) begin
            bus.wgt_wr_en   = 1'b1;
            bus.wgt_wr_addr = 3'(i);
            bus.wgt_wr_data = w;
            tick();
        end
        bus.wgt_wr_en = 1'b0;
    endtask

    // Issue one job, feed pixels with valid held high, collect outputs until done
    task automatic run_job(input int k, input int n);
        bit take;
        int stall_left;
        bit have_stall;
        got.delete();
        done_cnt = 0; pix_taken = 0; lat_loadw = -1; lat_valid = -1;
        stall_viol = 0; stall_cycles = 0; proto_viol = 0; timed_out = 1'b1;
        stall_left = stall_req; have_stall = 1'b0;
        bus.cfg_k    = 4'(k);
        bus.cfg_npix = 8'(n);
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.img_valid = 1'b1;
            bus.img_data  = (pix_taken < 16) ? pix[pix_taken] : '0;
            if (corrupt_req && bus.busy) begin
                bus.wgt_wr_en   = 1'b1;
                bus.wgt_wr_addr = 3'(cyc % 3);
                bus.wgt_wr_data = 16'sh1234;
            end else begin
                bus.wgt_wr_en = 1'b0;
            end
            if (bus.out_valid && stall_left > 0) begin
                bus.out_ready = 1'b0;
                if (!have_stall) begin
                    stall_data = bus.out_data;
                    have_stall = 1'b1;
                end
                if (bus.out_data !== stall_data || bus.img_ready || bus.pe_image_en || bus.pe_weight_en)
                    stall_viol++;
                stall_cycles++;
                stall_left--;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (bus.pe_image_en && bus.pe_weight_en) proto_viol++;
            if (bus.img_ready && (bus.out_valid || bus.pe_image_en || bus.pe_weight_en)) proto_viol++;
            if (bus.pe_weight_en && lat_loadw < 0) lat_loadw = cyc;
            if (bus.out_valid && lat_valid < 0) lat_valid = cyc;
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            if (bus.done) done_cnt++;
            take = bus.img_valid && bus.img_ready;
            tick();
            if (take) pix_taken++;
            if (done_cnt > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        bus.img_valid = 1'b0;
        bus.wgt_wr_en = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    function automatic logic signed [DW-1:0] got_at(input int i);
        return (got.size() > i) ? got[i] : 16'shxxxx;
    endfunction

    task automatic set_ramp();
        for (int i = 0; i < 16; i++) pix[i] = 16'(256 * (i + 1));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        total++; if (bus.busy !== 1'b0)         begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0)         begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.out_valid !== 1'b0)    begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.img_ready !== 1'b0)    begin bad++; $display("FAIL reset_img_ready got=%b want=0", bus.img_ready); end
        total++; if (bus.pe_image_en !== 1'b0)  begin bad++; $display("FAIL reset_pe_image_en got=%b want=0", bus.pe_image_en); end
        total++; if (bus.pe_weight_en !== 1'b0) begin bad++; $display("FAIL reset_pe_weight_en got=%b want=0", bus.pe_weight_en); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        load_w(3, 16'sd256);
        set_ramp();
        run_job(3, 4);
        total++; if (timed_out !== 1'b0)      begin bad++; $display("FAIL basic_timeout got=%b want=0", timed_out); end
        total++; if (got.size() !== 2)        begin bad++; $display("FAIL basic_count got=%0d want=2", got.size()); end
        total++; if (got_at(0) !== 16'sd1536) begin bad++; $display("FAIL basic_y0 got=%0d want=1536", got_at(0)); end
        total++; if (got_at(1) !== 16'sd2304) begin bad++; $display("FAIL basic_y1 got=%0d want=2304", got_at(1)); end
        total++; if (done_cnt !== 1)          begin bad++; $display("FAIL basic_done got=%0d want=1", done_cnt); end
        total++; if (bus.busy !== 1'b0)       begin bad++; $display("FAIL basic_busy_after got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0)       begin bad++; $display("FAIL basic_done_pulse got=%b want=0", bus.done); end
        total++; if (pix_taken !== 4)         begin bad++; $display("FAIL basic_pixels got=%0d want=4", pix_taken); end
        total++; if (lat_valid - lat_loadw !== 6) begin bad++; $display("FAIL basic_latency got=%0d want=6", lat_valid - lat_loadw); end
        total++; if (proto_viol !== 0)        begin bad++; $display("FAIL basic_protocol got=%0d want=0", proto_viol); end
    endtask

    task automatic test_negative();
        logic signed [DW-1:0] e0, e1;
`ifdef PE_SEQ_CTRL_RELU_EN
        e0 = 16'sd0;     e1 = 16'sd0;
`else
        e0 = -16'sd1536; e1 = -16'sd2304;
`endif
        load_w(3, -16'sd256);
        set_ramp();
        run_job(3, 4);
        total++; if (got.size() !== 2) begin bad++; $display("FAIL neg_count got=%0d want=2", got.size()); end
        total++; if (got_at(0) !== e0) begin bad++; $display("FAIL neg_y0 got=%0d want=%0d", got_at(0), e0); end
        total++; if (got_at(1) !== e1) begin bad++; $display("FAIL neg_y1 got=%0d want=%0d", got_at(1), e1); end
    endtask

    task automatic test_patterns();
        logic signed [DW-1:0] e1;
        // K=1, weight 2.0
        load_w(1, 16'sd512);
        pix[0] = 16'sd256; pix[1] = -16'sd256; pix[2] = 16'sd768;
`ifdef PE_SEQ_CTRL_RELU_EN
        e1 = 16'sd0;
`else
        e1 = -16'sd512;
`endif
        run_job(1, 3);
        total++; if (got.size() !== 3)        begin bad++; $display("FAIL k1_count got=%0d want=3", got.size()); end
        total++; if (got_at(0) !== 16'sd512)  begin bad++; $display("FAIL k1_y0 got=%0d want=512", got_at(0)); end
        total++; if (got_at(1) !== e1)        begin bad++; $display("FAIL k1_y1 got=%0d want=%0d", got_at(1), e1); end
        total++; if (got_at(2) !== 16'sd1536) begin bad++; $display("FAIL k1_y2 got=%0d want=1536", got_at(2)); end
        // K=2, weights {1.0, 2.0}
        bus.wgt_wr_en = 1'b1; bus.wgt_wr_addr = 3'd0; bus.wgt_wr_data = 16'sd256; tick();
        bus.wgt_wr_addr = 3'd1; bus.wgt_wr_data = 16'sd512; tick();
        bus.wgt_wr_en = 1'b0;
        set_ramp();
        run_job(2, 3);
        total++; if (got_at(0) !== 16'sd1280) begin bad++; $display("FAIL k2_y0 got=%0d want=1280", got_at(0)); end
        total++; if (got_at(1) !== 16'sd2048) begin bad++; $display("FAIL k2_y1 got=%0d want=2048", got_at(1)); end
        total++; if (lat_valid - lat_loadw !== 4) begin bad++; $display("FAIL k2_latency got=%0d want=4", lat_valid - lat_loadw); end
        // K=KMAX with N=K: a single output
        load_w(8, 16'sd256);
        for (int i = 0; i < 16; i++) pix[i] = 16'sd256;
        run_job(8, 8);
        total++; if (got.size() !== 1)        begin bad++; $display("FAIL kmax_count got=%0d want=1", got.size()); end
        total++; if (got_at(0) !== 16'sd2048) begin bad++; $display("FAIL kmax_y0 got=%0d want=2048", got_at(0)); end
        total++; if (pix_taken !== 8)         begin bad++; $display("FAIL kmax_pixels got=%0d want=8", pix_taken); end
    endtask

    task automatic test_stall();
        load_w(3, 16'sd256);
        set_ramp();
        stall_req = 5;
        run_job(3, 4);
        stall_req = 0;
        total++; if (stall_cycles !== 5)      begin bad++; $display("FAIL stall_cycles got=%0d want=5", stall_cycles); end
        total++; if (stall_viol !== 0)        begin bad++; $display("FAIL stall_hold got=%0d want=0", stall_viol); end
        total++; if (got_at(0) !== 16'sd1536) begin bad++; $display("FAIL stall_y0 got=%0d want=1536", got_at(0)); end
        total++; if (got_at(1) !== 16'sd2304) begin bad++; $display("FAIL stall_y1 got=%0d want=2304", got_at(1)); end
    endtask

    task automatic test_bad_start();
        int act;
        for (int s = 0; s < 2; s++) begin
            act = 0;
            bus.cfg_k    = (s == 0) ? 4'd0 : 4'd3;
            bus.cfg_npix = (s == 0) ? 8'd4 : 8'd2;
            bus.img_valid = 1'b1;
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            for (int c = 0; c < 6; c++) begin
                if (bus.busy || bus.img_ready || bus.done) act++;
                tick();
            end
            bus.img_valid = 1'b0;
            total++; if (act !== 0) begin bad++; $display("FAIL bad_start_%0d got=%0d want=0", s, act); end
        end
    endtask

    task automatic test_reset_mid_job();
        int mac_seen = 0;
        int idx = 0;
        int act = 0;
        bit hit = 1'b0;
        bit take;
        load_w(3, 16'sd256);
        set_ramp();
        bus.cfg_k = 4'd3; bus.cfg_npix = 8'd4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.img_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            bus.img_data = pix[idx];
            if (bus.pe_image_en) mac_seen++;
            if (mac_seen == 2) begin
                hit = 1'b1;
                break;
            end
            take = bus.img_ready;
            tick();
            if (take) idx++;
        end
        rst = 1'b1;
        tick();
        total++; if (hit !== 1'b1)              begin bad++; $display("FAIL rmid_reach got=%b want=1", hit); end
        total++; if (bus.busy !== 1'b0)         begin bad++; $display("FAIL rmid_busy got=%b want=0", bus.busy); end
        total++; if (bus.out_valid !== 1'b0)    begin bad++; $display("FAIL rmid_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.img_ready !== 1'b0)    begin bad++; $display("FAIL rmid_img_ready got=%b want=0", bus.img_ready); end
        total++; if (bus.pe_image_en !== 1'b0)  begin bad++; $display("FAIL rmid_pe_image_en got=%b want=0", bus.pe_image_en); end
        total++; if (bus.pe_weight_en !== 1'b0) begin bad++; $display("FAIL rmid_pe_weight_en got=%b want=0", bus.pe_weight_en); end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.out_valid || bus.done || bus.busy) act++;
            tick();
        end
        bus.img_valid = 1'b0;
        total++; if (act !== 0) begin bad++; $display("FAIL rmid_quiet got=%0d want=0", act); end
        // Weights were cleared by reset
        run_job(3, 4);
        total++; if (got_at(0) !== 16'sd0) begin bad++; $display("FAIL rmid_wclr_y0 got=%0d want=0", got_at(0)); end
        total++; if (got_at(1) !== 16'sd0) begin bad++; $display("FAIL rmid_wclr_y1 got=%0d want=0", got_at(1)); end
        load_w(3, 16'sd256);
        run_job(3, 4);
        total++; if (got_at(0) !== 16'sd1536) begin bad++; $display("FAIL rmid_y0 got=%0d want=1536", got_at(0)); end
        total++; if (got_at(1) !== 16'sd2304) begin bad++; $display("FAIL rmid_y1 got=%0d want=2304", got_at(1)); end
    endtask

    task automatic test_wgt_locked();
        load_w(3, 16'sd256);
        set_ramp();
        corrupt_req = 1'b1;
        run_job(3, 4);
        corrupt_req = 1'b0;
        total++; if (got_at(0) !== 16'sd1536) begin bad++; $display("FAIL wlock_y0 got=%0d want=1536", got_at(0)); end
        total++; if (got_at(1) !== 16'sd2304) begin bad++; $display("FAIL wlock_y1 got=%0d want=2304", got_at(1)); end
        // Second job on untouched weights confirms nothing leaked in
        run_job(3, 4);
        total++; if (got_at(0) !== 16'sd1536) begin bad++; $display("FAIL wlock_again_y0 got=%0d want=1536", got_at(0)); end
    endtask

    task automatic test_back_to_back();
        load_w(3, 16'sd256);
        set_ramp();
        run_job(3, 5);
        total++; if (got.size() !== 3)        begin bad++; $display("FAIL b2b_count got=%0d want=3", got.size()); end
        total++; if (got_at(2) !== 16'sd3072) begin bad++; $display("FAIL b2b_y2 got=%0d want=3072", got_at(2)); end
        run_job(3, 3);
        total++; if (got.size() !== 1)        begin bad++; $display("FAIL b2b2_count got=%0d want=1", got.size()); end
        total++; if (got_at(0) !== 16'sd1536) begin bad++; $display("FAIL b2b2_y0 got=%0d want=1536", got_at(0)); end
    endtask

    initial begin
        bus.start = 1'b0; bus.cfg_k = '0; bus.cfg_npix = '0;
        bus.wgt_wr_en = 1'b0; bus.wgt_wr_addr = '0; bus.wgt_wr_data = '0;
        bus.img_valid = 1'b0; bus.img_data = '0; bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_negative();
        test_patterns();
        test_stall();
        test_bad_start();
        test_reset_mid_job();
        test_wgt_locked();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
